// File: rtl/jogo_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : jogo_pkg
//  Description : Shared definitions for the memory-game control unit:
//                4-bit state codes shown on the hex display, the state
//                enumeration built on them, and the default timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
package jogo_pkg;

    // Default number of cycles allowed in ESPERA before a timeout
    localparam int c_timeout_padrao = 5000;
    // Default timeout counter width (2**13 > 5000)
    localparam int c_tmo_w_padrao   = 13;

    // State codes as shown on the debug hex display
    localparam logic [3:0] c_cod_inicial    = 4'h0;
    localparam logic [3:0] c_cod_prepara    = 4'h1;
    localparam logic [3:0] c_cod_espera     = 4'h2;
    localparam logic [3:0] c_cod_registra   = 4'h4;
    localparam logic [3:0] c_cod_compara    = 4'h5;
    localparam logic [3:0] c_cod_proximo    = 4'h6;
    localparam logic [3:0] c_cod_fim_acerto = 4'hA;
    localparam logic [3:0] c_cod_fim_tmo    = 4'hD;
    localparam logic [3:0] c_cod_fim_erro   = 4'hE;

    typedef enum logic [3:0] {
        ST_INICIAL    = c_cod_inicial,
        ST_PREPARA    = c_cod_prepara,
        ST_ESPERA     = c_cod_espera,
        ST_REGISTRA   = c_cod_registra,
        ST_COMPARA    = c_cod_compara,
        ST_PROXIMO    = c_cod_proximo,
        ST_FIM_ACERTO = c_cod_fim_acerto,
        ST_FIM_TMO    = c_cod_fim_tmo,
        ST_FIM_ERRO   = c_cod_fim_erro
    } estado_t;

endpackage
`default_nettype wire

// File: rtl/edge_detector.sv
`default_nettype none
// ============================================================================
//  Module      : edge_detector
//  Description : Rising-edge detector. Produces a one-cycle pulse on the
//                first cycle the input is high; a level held high for many
//                cycles gives exactly one pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module edge_detector (
    input  logic clock,
    input  logic reset,
    input  logic sinal,
    output logic pulso
);

    logic r_sinal_d;

    // Delay the input by one cycle so a rising edge can be recognised
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sinal_d <= 1'b0;
        end else begin
            r_sinal_d <= sinal;
        end
    end

    assign pulso = sinal & ~r_sinal_d;

endmodule
`default_nettype wire

// File: rtl/unidade_controle_jogo.sv
`default_nettype none
// ============================================================================
//  Module      : unidade_controle_jogo
//  Description : Moore control unit of the memory game. Waits for iniciar,
//                clears the datapath, then for every key press registers
//                the play, compares it with memory and advances the address
//                counter, ending in hit, miss or timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module unidade_controle_jogo
    import jogo_pkg::*;
#(
    parameter int TIMEOUT = c_timeout_padrao,
    parameter int TMO_W   = c_tmo_w_padrao
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       fimC,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic       pronto,
    output logic [3:0] db_estado
);

    // Last counter value that still counts as "waiting"
    localparam logic [TMO_W-1:0] c_tmo_fim = TMO_W'(TIMEOUT - 1);
    // Saturation ceiling for the timeout counter
    localparam logic [TMO_W-1:0] c_tmo_max = '1;

    estado_t          r_estado;
    estado_t          w_proximo;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             w_pulso;

    // One pulse per key press, however long the key is held
    edge_detector u_detector_jogada (
        .clock (clock),
        .reset (reset),
        .sinal (jogada),
        .pulso (w_pulso)
    );

    // State register and wait-time counter (counts only while in ESPERA)
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado  <= ST_INICIAL;
            r_tmo_cnt <= '0;
        end else begin
            r_estado <= w_proximo;
            if (r_estado != ST_ESPERA) begin
                r_tmo_cnt <= '0;
            end else if (r_tmo_cnt != c_tmo_max) begin
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end
        end
    end

    // Next-state logic; a key press wins over a simultaneous timeout
    always_comb begin
        w_proximo = ST_INICIAL;
        case (r_estado)
            ST_INICIAL: begin
                w_proximo = iniciar ? ST_PREPARA : ST_INICIAL;
            end
            ST_PREPARA: begin
                w_proximo = ST_ESPERA;
            end
            ST_ESPERA: begin
                if (w_pulso) begin
                    w_proximo = ST_REGISTRA;
                end else if (r_tmo_cnt == c_tmo_fim) begin
                    w_proximo = ST_FIM_TMO;
                end else begin
                    w_proximo = ST_ESPERA;
                end
            end
            ST_REGISTRA: begin
                w_proximo = ST_COMPARA;
            end
            ST_COMPARA: begin
                if (!igual) begin
                    w_proximo = ST_FIM_ERRO;
                end else if (fimC) begin
                    w_proximo = ST_FIM_ACERTO;
                end else begin
                    w_proximo = ST_PROXIMO;
                end
            end
            ST_PROXIMO: begin
                w_proximo = ST_ESPERA;
            end
            ST_FIM_ACERTO, ST_FIM_TMO, ST_FIM_ERRO: begin
                w_proximo = iniciar ? ST_PREPARA : r_estado;
            end
            default: begin
                w_proximo = ST_INICIAL;
            end
        endcase
    end

    // Moore outputs decoded from the state register only
    always_comb begin
        zeraC     = 1'b0;
        contaC    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        timeout   = 1'b0;
        pronto    = 1'b0;
        case (r_estado)
            ST_PREPARA: begin
                zeraC = 1'b1;
                zeraR = 1'b1;
            end
            ST_REGISTRA: begin
                registraR = 1'b1;
            end
            ST_PROXIMO: begin
                contaC = 1'b1;
            end
            ST_FIM_ACERTO: begin
                acertou = 1'b1;
                pronto  = 1'b1;
            end
            ST_FIM_ERRO: begin
                errou  = 1'b1;
                pronto = 1'b1;
            end
            ST_FIM_TMO: begin
                timeout = 1'b1;
                pronto  = 1'b1;
            end
            default: begin
                pronto = 1'b0;
            end
        endcase
    end

    assign db_estado = r_estado;

endmodule
`default_nettype wire

// File: tb/tb_unidade_controle_jogo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_unidade_controle_jogo
//  Description : Self-checking bench for the memory-game control unit.
//                A rule-level game model runs beside the DUT and is compared
//                every cycle; directed scenarios pin key values literally,
//                followed by a randomized run with a small datapath emulator.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_unidade_controle_jogo;

    localparam int TIMEOUT   = 20;
    localparam int TMO_W     = 5;
    localparam int N_JOGADAS = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic       jogada = 1'b0;
    logic       igual;
    logic       fimC;
    logic       zeraC, contaC, zeraR, registraR;
    logic       acertou, errou, timeout, pronto;
    logic [3:0] db_estado;
    logic [7:0] saidas;

    int checks = 0;
    int errors = 0;
    bit compare_on = 1'b0;

    // Datapath emulation: address counter and a chosen wrong address
    int addr = 0;
    int wrong_addr = 99;

    int n_registra = 0;
    int n_conta = 0;

    // Reference model state: display code, cycles spent waiting, last key
    int m_code = 0;
    int m_wait = 0;
    bit m_prev = 1'b0;

    unidade_controle_jogo #(
        .TIMEOUT (TIMEOUT),
        .TMO_W   (TMO_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .jogada    (jogada),
        .igual     (igual),
        .fimC      (fimC),
        .zeraC     (zeraC),
        .contaC    (contaC),
        .zeraR     (zeraR),
        .registraR (registraR),
        .acertou   (acertou),
        .errou     (errou),
        .timeout   (timeout),
        .pronto    (pronto),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    assign saidas = {zeraC, contaC, zeraR, registraR, acertou, errou, timeout, pronto};
    assign fimC   = (addr == N_JOGADAS - 1);
    assign igual  = (addr != wrong_addr);

    // Address counter of the emulated datapath
    always @(posedge clock) begin
        if (zeraC) addr <= 0;
        else if (contaC) addr <= addr + 1;
    end

    // Count output pulses for the directed scenarios
    always @(negedge clock) begin
        if (registraR) n_registra <= n_registra + 1;
        if (contaC) n_conta <= n_conta + 1;
    end

    // Game rules: where the game goes next from the current phase
    function automatic int model_next(input int code, input int espera, input bit tecla,
                                      input bit ini, input bit ig, input bit fim);
        case (code)
            0:           return ini ? 1 : 0;
            1:           return 2;
            2:           return tecla ? 4 : (espera == TIMEOUT - 1) ? 13 : 2;
            4:           return 5;
            5:           return !ig ? 14 : fim ? 10 : 6;
            6:           return 2;
            10, 13, 14:  return ini ? 1 : code;
            default:     return 0;
        endcase
    endfunction

    // Outputs required in each phase: {zeraC,contaC,zeraR,registraR,acertou,errou,timeout,pronto}
    function automatic logic [7:0] expect_out(input int code);
        case (code)
            1:       return 8'b1010_0000;
            4:       return 8'b0001_0000;
            6:       return 8'b0100_0000;
            10:      return 8'b0000_1001;
            14:      return 8'b0000_0101;
            13:      return 8'b0000_0011;
            default: return 8'b0000_0000;
        endcase
    endfunction

    // Reference model advance
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_code <= 0;
            m_wait <= 0;
            m_prev <= 1'b0;
        end else begin
            m_code <= model_next(m_code, m_wait, jogada && !m_prev, iniciar, igual, fimC);
            m_wait <= (m_code == 2) ? m_wait + 1 : 0;
            m_prev <= jogada;
        end
    end

    task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nome, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clock) begin
        if (compare_on) begin
            chk("model_saidas", {24'd0, saidas}, {24'd0, expect_out(m_code)});
            chk("model_db_estado", {28'd0, db_estado}, m_code);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic jogar(input int segurar, input int folga);
        jogada = 1'b1;
        repeat (segurar) tick();
        jogada = 1'b0;
        repeat (folga) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not end, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, c0, taxa;
        repeat (3) @(posedge clock);
        #1;
        compare_on = 1'b1;

        // Reset state
        chk("reset_db_estado", {28'd0, db_estado}, 0);
        chk("reset_saidas", {24'd0, saidas}, 0);
        reset = 1'b1;
        tick();
        chk("inicial_sem_iniciar", {28'd0, db_estado}, 0);

        // iniciar held 5 cycles: one PREPARA cycle then ESPERA
        iniciar = 1'b1;
        tick();
        chk("prepara_db", {28'd0, db_estado}, 1);
        chk("prepara_zeras", {30'd0, zeraC, zeraR}, 3);
        repeat (4) begin
            tick();
            chk("espera_ignora_iniciar", {28'd0, db_estado}, 2);
        end
        iniciar = 1'b0;

        // 16 correct plays, first one with latency checks
        r0 = n_registra;
        c0 = n_conta;
        jogada = 1'b1;
        tick();
        chk("latencia_registraR", {31'd0, registraR}, 1);
        jogada = 1'b0;
        tick();
        chk("latencia_compara", {28'd0, db_estado}, 5);
        tick();
        chk("latencia_proximo", {31'd0, contaC}, 1);
        repeat (2) tick();
        repeat (N_JOGADAS - 1) jogar(1, 4);
        chk("acerto_n_registra", n_registra - r0, 16);
        chk("acerto_n_conta", n_conta - c0, 15);
        chk("acerto_db", {28'd0, db_estado}, 10);
        chk("acerto_flags", {29'd0, acertou, pronto, errou}, 6);
        chk("modelo_acerto", m_code, 10);

        // Wrong third play
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        tick();
        wrong_addr = 2;
        c0 = n_conta;
        repeat (3) jogar(1, 4);
        chk("erro_db", {28'd0, db_estado}, 14);
        chk("erro_flags", {29'd0, errou, pronto, acertou}, 6);
        chk("erro_n_conta", n_conta - c0, 2);

        // Restart from FIM_ERRO clears errou
        iniciar = 1'b1;
        tick();
        chk("reinicio_db", {28'd0, db_estado}, 1);
        chk("reinicio_errou", {30'd0, errou, pronto}, 0);
        iniciar = 1'b0;
        wrong_addr = 99;
        tick();

        // Key held 10 cycles gives a single registration
        r0 = n_registra;
        c0 = n_conta;
        jogar(10, 2);
        chk("tecla_presa_registra", n_registra - r0, 1);
        chk("tecla_presa_conta", n_conta - c0, 1);
        chk("tecla_presa_db", {28'd0, db_estado}, 2);

        // Reset mid-game while in REGISTRA drops outputs at once
        jogada = 1'b1;
        tick();
        chk("pre_reset_registraR", {31'd0, registraR}, 1);
        reset = 1'b0;
        jogada = 1'b0;
        #1;
        chk("reset_async_db", {28'd0, db_estado}, 0);
        chk("reset_async_saidas", {24'd0, saidas}, 0);
        tick();
        reset = 1'b1;
        tick();

        // Timeout after exactly TIMEOUT idle cycles
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        tick();
        repeat (TIMEOUT - 1) tick();
        chk("tmo_ainda_espera", {28'd0, db_estado}, 2);
        tick();
        chk("tmo_db", {28'd0, db_estado}, 13);
        chk("tmo_flags", {30'd0, timeout, pronto}, 3);
        chk("modelo_tmo", m_code, 13);

        // Key press on the last waiting cycle wins over timeout
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        tick();
        repeat (TIMEOUT - 1) tick();
        jogada = 1'b1;
        tick();
        chk("tmo_pulso_vence", {28'd0, db_estado}, 4);
        jogada = 1'b0;
        repeat (4) tick();

        // Randomized run against the model
        taxa = 4;
        for (int i = 0; i < 4000; i++) begin
            if (i % 64 == 0) begin
                case ($urandom_range(0, 2))
                    0:       taxa = 2;
                    1:       taxa = 4;
                    default: taxa = 40;
                endcase
            end
            reset   = ($urandom_range(0, 599) != 0);
            iniciar = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, taxa - 1) == 0) jogada = ~jogada;
            if ($urandom_range(0, 49) == 0) wrong_addr = $urandom_range(0, 40);
            tick();
        end

        compare_on = 1'b0;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
